// File: rtl/pe_mac_q.sv
`default_nettype none
// ============================================================================
// Module  : pe_mac_q
// Brief   : Weight-stationary Q-format MAC processing element (systolic pass-
//           down or local accumulate) with rounding and saturation.
// Rev     : 1.0
// ============================================================================
module pe_mac_q #(
  parameter int DW      = 16,
  parameter int FRAC    = 13,
  parameter int MUL_LAT = 2
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_W_LD,
  input  logic [DW-1:0] I_W,
  input  logic          I_MODE,
  input  logic          I_X_VLD,
  input  logic [DW-1:0] I_X,
  input  logic          I_D_VLD,
  input  logic [DW-1:0] I_D,
  input  logic          I_CLR,
  input  logic          I_DRAIN,
  output logic          O_X_VLD,
  output logic [DW-1:0] O_X,
  output logic          O_OUT_VLD,
  output logic [DW-1:0] O_OUT,
  output logic          O_SAT,
  output logic          O_BUSY
);

  localparam int c_PW = 2 * DW;
  localparam int c_LS = MUL_LAT - 1;
  localparam logic [c_PW-1:0] c_HALF = {{(c_PW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic [DW-1:0]   c_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   c_MIN  = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0]                 r_w;
  logic [MUL_LAT-1:0]            r_v;
  logic [MUL_LAT-1:0]            r_m;
  logic [MUL_LAT-1:0][c_PW-1:0]  r_p;
  logic [MUL_LAT-1:0][DW-1:0]    r_d;
  logic [DW-1:0]                 r_x_fwd;
  logic                          r_x_vld;
  logic [DW-1:0]                 r_acc;
  logic [DW-1:0]                 r_out;
  logic                          r_out_vld;
  logic                          r_sat;
  logic                          r_drain_pend;
  logic                          r_busy;

  logic [MUL_LAT:0]              w_v_ext;
  logic [MUL_LAT:0]              w_m_ext;
  logic [c_PW-1:0]               w_x_ext;
  logic [c_PW-1:0]               w_w_ext;
  logic [c_PW-1:0]               w_prod;
  logic                          w_land;
  logic                          w_land0;
  logic                          w_land1;
  logic signed [c_PW-1:0]        w_rnd;
  logic signed [c_PW-1:0]        w_shf;
  logic                          w_p_ovf;
  logic [DW-1:0]                 w_p_sat;
  logic [DW-1:0]                 w_acc_base;
  logic [DW-1:0]                 w_addend;
  logic [DW:0]                   w_sum;
  logic                          w_s_ovf;
  logic [DW-1:0]                 w_sum_sat;
  logic [DW-1:0]                 w_acc_next;
  logic                          w_drain;
  logic                          w_clamp;

  assign w_v_ext = {r_v, I_X_VLD};
  assign w_m_ext = {r_m, I_MODE};

  // Low 2*DW bits of the sign-extended product equal the signed product.
  assign w_x_ext = {{DW{I_X[DW-1]}}, I_X};
  assign w_w_ext = {{DW{r_w[DW-1]}}, r_w};
  assign w_prod  = w_x_ext * w_w_ext;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_w     <= '0;
      r_v     <= '0;
      r_m     <= '0;
      r_p     <= '0;
      r_d     <= '0;
      r_x_fwd <= '0;
      r_x_vld <= 1'b0;
    end else begin
      if (I_W_LD) r_w <= I_W;
      r_v <= w_v_ext[MUL_LAT-1:0];
      r_m <= w_m_ext[MUL_LAT-1:0];
      if (I_X_VLD) begin
        r_p[0] <= w_prod;
        r_d[0] <= I_D_VLD ? I_D : '0;
      end
      for (int k = 1; k < MUL_LAT; k++) begin
        if (r_v[k-1]) begin
          r_p[k] <= r_p[k-1];
          r_d[k] <= r_d[k-1];
        end
      end
      r_x_vld <= I_X_VLD;
      if (I_X_VLD) r_x_fwd <= I_X;
    end
  end

  assign w_land  = r_v[c_LS];
  assign w_land0 = w_land & ~r_m[c_LS];
  assign w_land1 = w_land &  r_m[c_LS];

  // Half-up rounding, then clamp if the upper DW+1 bits are not a sign run.
  assign w_rnd   = $signed(r_p[c_LS]) + $signed(c_HALF);
  assign w_shf   = w_rnd >>> FRAC;
  assign w_p_ovf = ~((&w_shf[c_PW-1:DW-1]) | ~(|w_shf[c_PW-1:DW-1]));
  assign w_p_sat = w_p_ovf ? (w_shf[c_PW-1] ? c_MIN : c_MAX) : w_shf[DW-1:0];

  // Clear-then-add: a product landing with I_CLR starts a fresh accumulator.
  assign w_acc_base = I_CLR ? '0 : r_acc;
  assign w_addend   = r_m[c_LS] ? w_acc_base : r_d[c_LS];
  assign w_sum      = {w_p_sat[DW-1], w_p_sat} + {w_addend[DW-1], w_addend};
  assign w_s_ovf    = w_sum[DW] ^ w_sum[DW-1];
  assign w_sum_sat  = w_s_ovf ? (w_sum[DW] ? c_MIN : c_MAX) : w_sum[DW-1:0];
  assign w_acc_next = w_land1 ? w_sum_sat : w_acc_base;

  assign w_drain = I_DRAIN | r_drain_pend;
  assign w_clamp = w_land & (w_p_ovf | w_s_ovf);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_acc        <= '0;
      r_out        <= '0;
      r_out_vld    <= 1'b0;
      r_sat        <= 1'b0;
      r_drain_pend <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy       <= |w_v_ext[MUL_LAT-1:0];
      r_sat        <= (r_sat & ~I_CLR) | w_clamp;
      // A mode-0 result owns the output port; a colliding drain waits a cycle.
      r_drain_pend <= w_land0 & w_drain;
      r_out_vld    <= w_land0 | w_drain;
      if (w_land0)      r_out <= w_sum_sat;
      else if (w_drain) r_out <= w_acc_next;
      r_acc        <= (w_drain & ~w_land0) ? '0 : w_acc_next;
    end
  end

  assign O_X_VLD   = r_x_vld;
  assign O_X       = r_x_fwd;
  assign O_OUT_VLD = r_out_vld;
  assign O_OUT     = r_out;
  assign O_SAT     = r_sat;
  assign O_BUSY    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_q.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_mac_q
// Brief   : Self-checking bench for pe_mac_q: directed vector table, corner
//           sequences and randomized traffic against a reference model.
// Rev     : 1.0
// ============================================================================
module tb_pe_mac_q;

  localparam int DW      = 16;
  localparam int FRAC    = 13;
  localparam int MUL_LAT = 2;
  localparam logic [31:0] c_MASK = (32'd1 << DW) - 32'd1;

  logic          I_CLK   = 1'b0;
  logic          I_RST_N = 1'b0;
  logic          I_W_LD  = 1'b0;
  logic [DW-1:0] I_W     = '0;
  logic          I_MODE  = 1'b0;
  logic          I_X_VLD = 1'b0;
  logic [DW-1:0] I_X     = '0;
  logic          I_D_VLD = 1'b0;
  logic [DW-1:0] I_D     = '0;
  logic          I_CLR   = 1'b0;
  logic          I_DRAIN = 1'b0;
  logic          O_X_VLD;
  logic [DW-1:0] O_X;
  logic          O_OUT_VLD;
  logic [DW-1:0] O_OUT;
  logic          O_SAT;
  logic          O_BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 I_CLK = ~I_CLK;

  pe_mac_q #(.DW(DW), .FRAC(FRAC), .MUL_LAT(MUL_LAT)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_W_LD(I_W_LD), .I_W(I_W),
    .I_MODE(I_MODE), .I_X_VLD(I_X_VLD), .I_X(I_X), .I_D_VLD(I_D_VLD),
    .I_D(I_D), .I_CLR(I_CLR), .I_DRAIN(I_DRAIN), .O_X_VLD(O_X_VLD),
    .O_X(O_X), .O_OUT_VLD(O_OUT_VLD), .O_OUT(O_OUT), .O_SAT(O_SAT),
    .O_BUSY(O_BUSY)
  );

  // Reference model: samples in flight with their landing cycle.
  typedef struct { int land; int x; int w; int d; bit mode; } smp_t;
  smp_t q[$];
  int  m_w, m_acc, m_out, m_x, cyc;
  bit  m_vld, m_xv, m_sat, m_pend;

  typedef struct {
    logic [DW-1:0] w; logic [DW-1:0] x; logic [DW-1:0] d; bit dv;
    logic [DW-1:0] eo; bit es;
  } vec_t;
  vec_t vt[8];

  function automatic int sx(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [31:0] u(int v);
    logic [31:0] t;
    t = v;
    return t & c_MASK;
  endfunction

  function automatic int clampv(longint v, inout bit hit);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) begin hit = 1'b1; return int'(hi); end
    if (v < lo) begin hit = 1'b1; return int'(lo); end
    return int'(v);
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom);
      1: case ($urandom_range(0, 3))
           0: v = 32'h7FFF;
           1: v = 32'h8000;
           2: v = -1;
           default: v = 1;
         endcase
      default: v = int'($urandom_range(0, 24576)) - 12288;
    endcase
    return v[DW-1:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_w = 0; m_acc = 0; m_out = 0; m_x = 0;
    m_vld = 0; m_xv = 0; m_sat = 0; m_pend = 0;
  endtask

  // Predicts the state right after the coming rising edge.
  task automatic model_edge();
    bit     hit, land0, drain;
    int     acc_n, res, p;
    longint prod;
    hit = 0; land0 = 0; res = 0;
    acc_n = I_CLR ? 0 : m_acc;
    if (I_CLR) m_sat = 0;
    if (q.size() > 0 && q[0].land == cyc) begin
      smp_t s;
      s = q.pop_front();
      prod = longint'(s.x) * longint'(s.w);
      p = clampv((prod + (longint'(1) <<< (FRAC - 1))) >>> FRAC, hit);
      if (s.mode) acc_n = clampv(longint'(acc_n) + longint'(p), hit);
      else begin
        res   = clampv(longint'(p) + longint'(s.d), hit);
        land0 = 1;
      end
    end
    m_sat = m_sat | hit;
    drain = I_DRAIN || m_pend;
    if (land0) begin
      m_out = res; m_vld = 1; m_pend = drain; m_acc = acc_n;
    end else if (drain) begin
      m_out = acc_n; m_vld = 1; m_pend = 0; m_acc = 0;
    end else begin
      m_vld = 0; m_pend = 0; m_acc = acc_n;
    end
    if (I_X_VLD)
      q.push_back('{cyc + MUL_LAT, sx(I_X), m_w, (I_D_VLD ? sx(I_D) : 0), I_MODE});
    if (I_W_LD) m_w = sx(I_W);
    m_xv = I_X_VLD;
    if (I_X_VLD) m_x = sx(I_X);
    cyc++;
  endtask

  task automatic check_all();
    chk("x_vld",   O_X_VLD,   m_xv);
    chk("x",       O_X,       u(m_x));
    chk("out_vld", O_OUT_VLD, m_vld);
    chk("out",     O_OUT,     u(m_out));
    chk("sat",     O_SAT,     m_sat);
    chk("busy",    O_BUSY,    q.size() != 0);
  endtask

  task automatic step();
    if (I_RST_N) model_edge();
    @(posedge I_CLK);
    #1;
    if (!I_RST_N) model_reset();
    check_all();
  endtask

  task automatic idle();
    I_W_LD = 0; I_X_VLD = 0; I_D_VLD = 0; I_MODE = 0; I_CLR = 0; I_DRAIN = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    model_reset();
    vt[0] = '{16'h1000, 16'h2000, 16'h0800, 1'b1, 16'h1800, 1'b0};
    vt[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 1'b1};
    vt[2] = '{16'h6000, 16'hE000, 16'hC000, 1'b1, 16'h8000, 1'b1};
    vt[3] = '{16'h1000, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0};
    vt[4] = '{16'h1000, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{16'h1000, 16'h2000, 16'h7000, 1'b0, 16'h1000, 1'b0};
    vt[6] = '{16'h2000, 16'h3000, 16'h3000, 1'b1, 16'h6000, 1'b0};
    vt[7] = '{16'h2000, 16'h6000, 16'h6000, 1'b1, 16'h7FFF, 1'b1};

    step();
    step();
    chk("rst_out_vld", O_OUT_VLD, 0);
    chk("rst_busy", O_BUSY, 0);
    I_RST_N = 1;
    idle();
    step();

    // Directed mode-0 vectors, each from a cleared sticky flag.
    for (int i = 0; i < 8; i++) begin
      idle(); I_CLR = 1; I_W_LD = 1; I_W = vt[i].w;
      step();
      chk($sformatf("vec%0d_sat_clr", i), O_SAT, 0);
      idle(); I_X_VLD = 1; I_X = vt[i].x; I_D = vt[i].d; I_D_VLD = vt[i].dv;
      step();
      chk($sformatf("vec%0d_fwd_x", i), O_X, vt[i].x);
      idle();
      for (int k = 1; k <= MUL_LAT; k++) begin
        step();
        chk($sformatf("vec%0d_vld_t%0d", i, k), O_OUT_VLD, k == MUL_LAT);
      end
      chk($sformatf("vec%0d_out", i), O_OUT, vt[i].eo);
      chk($sformatf("vec%0d_sat", i), O_SAT, vt[i].es);
      step();
      chk($sformatf("vec%0d_pulse", i), O_OUT_VLD, 0);
    end

    // Local accumulate: four quarter-products, then two drains.
    idle(); I_CLR = 1; I_W_LD = 1; I_W = 16'h0800;
    step();
    idle(); I_MODE = 1; I_X_VLD = 1; I_X = 16'h2000;
    for (int k = 0; k < 4; k++) begin step(); chk("acc_no_vld", O_OUT_VLD, 0); end
    idle();
    for (int k = 0; k < MUL_LAT; k++) begin step(); chk("acc_no_vld", O_OUT_VLD, 0); end
    I_DRAIN = 1; step();
    chk("drain1_vld", O_OUT_VLD, 1);
    chk("drain1_out", O_OUT, 16'h2000);
    idle(); step();
    chk("drain1_pulse", O_OUT_VLD, 0);
    I_DRAIN = 1; step();
    chk("drain2_vld", O_OUT_VLD, 1);
    chk("drain2_out", O_OUT, 16'h0000);
    idle(); step();

    // Drain colliding with a landing mode-0 result.
    idle(); I_CLR = 1; I_W_LD = 1; I_W = 16'h1000;
    step();
    idle(); I_MODE = 1; I_X_VLD = 1; I_X = 16'h2000;
    step();
    I_MODE = 0; I_X = 16'h4000; I_D = 16'h0100; I_D_VLD = 1;
    step();
    idle();
    repeat (MUL_LAT - 1) step();
    I_DRAIN = 1; step();
    chk("coll_m0_vld", O_OUT_VLD, 1);
    chk("coll_m0_out", O_OUT, 16'h2100);
    idle(); step();
    chk("coll_drain_vld", O_OUT_VLD, 1);
    chk("coll_drain_out", O_OUT, 16'h1000);
    step();
    chk("coll_idle_vld", O_OUT_VLD, 0);

    // I_CLR in the cycle a mode-1 product lands.
    idle(); I_MODE = 1; I_X_VLD = 1; I_X = 16'h2000;
    step();
    idle();
    repeat (MUL_LAT) step();
    I_MODE = 1; I_X_VLD = 1; I_X = 16'h0800;
    step();
    idle();
    repeat (MUL_LAT - 1) step();
    I_CLR = 1; step();
    idle(); I_DRAIN = 1; step();
    chk("clr_land_vld", O_OUT_VLD, 1);
    chk("clr_land_out", O_OUT, 16'h0400);
    idle(); step();

    // Weight load in the same cycle as a sample.
    idle(); I_W_LD = 1; I_W = 16'h2000;
    step();
    idle(); I_W_LD = 1; I_W = 16'h4000; I_X_VLD = 1; I_X = 16'h1000;
    step();
    I_W_LD = 0;
    step();
    idle();
    repeat (MUL_LAT - 1) step();
    chk("whaz_old_vld", O_OUT_VLD, 1);
    chk("whaz_old_out", O_OUT, 16'h1000);
    step();
    chk("whaz_new_vld", O_OUT_VLD, 1);
    chk("whaz_new_out", O_OUT, 16'h2000);
    step();

    // Async reset with two samples in flight.
    idle(); I_X_VLD = 1; I_X = 16'h1000;
    step();
    step();
    idle(); I_RST_N = 0;
    #1;
    chk("arst_x_vld", O_X_VLD, 0);
    chk("arst_x", O_X, 0);
    chk("arst_out_vld", O_OUT_VLD, 0);
    chk("arst_out", O_OUT, 0);
    chk("arst_sat", O_SAT, 0);
    chk("arst_busy", O_BUSY, 0);
    step();
    I_RST_N = 1;
    repeat (MUL_LAT + 2) begin
      step();
      chk("arst_no_pulse", O_OUT_VLD, 0);
    end

    // Randomized traffic against the model.
    idle(); I_CLR = 1;
    step();
    for (int n = 0; n < 600; n++) begin
      I_X_VLD = ($urandom_range(0, 3) != 0);
      I_MODE  = 1'($urandom_range(0, 1));
      I_D_VLD = 1'($urandom_range(0, 1));
      I_X     = rnd_word();
      I_D     = rnd_word();
      I_W_LD  = ($urandom_range(0, 7) == 0);
      I_W     = rnd_word();
      I_DRAIN = ($urandom_range(0, 5) == 0);
      I_CLR   = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();
    repeat (MUL_LAT + 3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
